// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_e;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble add-3 correction for one BCD digit (combinational).
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // 10..15 never appear in a legal iteration; force a known zero instead of X
  always_comb begin
    if (din < ADJ_THRESH)     dout = din;
    else if (din <= BCD_MAX)  dout = din + 4'd3;
    else                      dout = 4'd0;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one shift-and-add-3 iteration per clock.
// Define BIN2BCD_QUEUE_EN to build a one-entry request buffer for starts while busy.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int TOT_W = 4*DIGITS + BIN_W;

  state_e                 state_q, state_d;
  logic [BIN_W-1:0]       bin_q, bin_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0]    res_q, res_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
`ifdef BIN2BCD_QUEUE_EN
  logic                   pend_q, pend_d;
  logic [BIN_W-1:0]       pbin_q, pbin_d;
`endif

  logic [4*DIGITS-1:0]    adj;
  logic [TOT_W-1:0]       shv;
  logic                   load;
  logic [BIN_W-1:0]       load_val;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_q[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    done_d   = 1'b0;
    load     = 1'b0;
    load_val = bin_in;
    shv      = {adj, bin_q} << 1;
`ifdef BIN2BCD_QUEUE_EN
    pend_d   = pend_q;
    pbin_d   = pbin_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef BIN2BCD_QUEUE_EN
        // a buffered request takes priority; ready is low so start is dropped
        if (pend_q) begin
          load     = 1'b1;
          load_val = pbin_q;
          pend_d   = 1'b0;
        end else
`endif
        if (start) load = 1'b1;
      end
      CONV: begin
        {bcd_d, bin_d} = shv;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          res_d   = bcd_d;
        end
`ifdef BIN2BCD_QUEUE_EN
        if (start && !pend_q) begin
          pend_d = 1'b1;
          pbin_d = bin_in;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = CONV;
      bin_d   = load_val;
      bcd_d   = '0;
      cnt_d   = CNT_W'(BIN_W);
    end
`ifdef BIN2BCD_QUEUE_EN
    ready_d = (state_d == IDLE) && !pend_d;
`else
    ready_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef BIN2BCD_QUEUE_EN
      pend_q  <= 1'b0;
      pbin_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef BIN2BCD_QUEUE_EN
      pend_q  <= pend_d;
      pbin_q  <= pbin_d;
`endif
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign bcd_out = res_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected BCD pushed at start, popped at done.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;
  localparam int LAT    = BIN_W + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [BIN_W-1:0]    bin_in = '0;
  logic                ready, done;
  logic [4*DIGITS-1:0] bcd_out;
  logic [3:0]          adj_in = '0;
  logic [3:0]          adj_out;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, done_cnt = 0;
  logic [4*DIGITS-1:0] exp_q[$];
  int                  acc_q[$];

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .ready(ready), .done(done), .bcd_out(bcd_out)
  );

  bcd_digit_adj u_adj (.din(adj_in), .dout(adj_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Drive one start for a single cycle; optionally log the expected result.
  task automatic pulse(input int v, input bit track);
    start = 1'b1;
    bin_in = BIN_W'(v);
    if (track) begin
      exp_q.push_back(ref_bcd(v));
      acc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle, or ok=0 after a cycle budget.
  task automatic wait_done(output bit ok, output int dcyc);
    ok = 1'b0; dcyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; dcyc = cyc; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (bcd_out !== 12'h000) begin n_bad++; $display("FAIL reset_bcd got %h want 000", bcd_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_adj;
    logic [3:0] e;
    for (int i = 0; i < 16; i++) begin
      adj_in = 4'(i);
      #1;
      e = (i < 5) ? 4'(i) : (i < 10) ? 4'(i + 3) : 4'd0;
      n_cmp++;
      if (adj_out !== e) begin n_bad++; $display("FAIL adj_%0d got %h want %h", i, adj_out, e); end
    end
  endtask

  task automatic test_single;
    int vals[4] = '{0, 255, 99, 5};
    logic [11:0] prev, e;
    bit ok; int dc, a;
    prev = 12'h000;
    @(posedge clk); #1;
    foreach (vals[k]) begin
      pulse(vals[k], 1'b1);
      @(negedge clk);
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready_%0d got %b want 0", vals[k], ready); end
      n_cmp++; if (bcd_out !== prev) begin n_bad++; $display("FAIL hold_%0d got %h want %h", vals[k], bcd_out, prev); end
      wait_done(ok, dc);
      e = exp_q.pop_front(); a = acc_q.pop_front();
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_%0d timeout waiting for done", vals[k]); end
      n_cmp++; if (bcd_out !== e) begin n_bad++; $display("FAIL single_%0d got %h want %h", vals[k], bcd_out, e); end
      n_cmp++; if (dc - a !== LAT) begin n_bad++; $display("FAIL latency_%0d got %0d want %0d", vals[k], dc - a, LAT); end
      prev = e;
    end
  endtask

  task automatic test_sweep;
    logic [11:0] e;
    bit ok; int dc, a;
    for (int v = 0; v < 256; v++) begin
      pulse(v, 1'b1);
      wait_done(ok, dc);
      e = exp_q.pop_front(); a = acc_q.pop_front();
      n_cmp++;
      if (!ok || bcd_out !== e || dc - a !== LAT) begin
        n_bad++;
        $display("FAIL sweep_%0d got %h (ok=%b lat=%0d) want %h lat %0d", v, bcd_out, ok, dc - a, e, LAT);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] e;
    bit ok; int dc, a, first;
    first = cyc;
    pulse(37, 1'b1);
    wait_done(ok, dc);
    e = exp_q.pop_front(); a = acc_q.pop_front();
    n_cmp++; if (!ok || bcd_out !== e || dc - first !== LAT) begin
      n_bad++; $display("FAIL b2b_first got %h at %0d want %h at %0d", bcd_out, dc - first, e, LAT); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_in_done got %b want 1", ready); end
    pulse(200, 1'b1);
    wait_done(ok, dc);
    e = exp_q.pop_front(); a = acc_q.pop_front();
    n_cmp++; if (!ok || bcd_out !== e || dc - first !== 2*LAT) begin
      n_bad++; $display("FAIL b2b_second got %h at %0d want %h at %0d", bcd_out, dc - first, e, 2*LAT); end
  endtask

  task automatic test_busy_start;
    logic [11:0] e;
    bit ok; int dc, a, first, d0;
    first = cyc;
    pulse(10, 1'b1);
    repeat (3) @(posedge clk);
    #1;
`ifdef BIN2BCD_QUEUE_EN
    pulse(77, 1'b1);
`else
    pulse(77, 1'b0);
`endif
    wait_done(ok, dc);
    e = exp_q.pop_front(); a = acc_q.pop_front();
    n_cmp++; if (!ok || bcd_out !== e || dc - first !== LAT) begin
      n_bad++; $display("FAIL busy_first got %h at %0d want %h at %0d", bcd_out, dc - first, e, LAT); end
`ifdef BIN2BCD_QUEUE_EN
    wait_done(ok, dc);
    e = exp_q.pop_front(); a = acc_q.pop_front();
    n_cmp++; if (!ok || bcd_out !== e || dc - first !== 2*LAT) begin
      n_bad++; $display("FAIL busy_queued got %h at %0d want %h at %0d", bcd_out, dc - first, e, 2*LAT); end
`endif
    @(posedge clk); #1;
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL busy_extra_done got %0d want %0d", done_cnt - d0, 0); end
    n_cmp++; if (bcd_out !== e) begin n_bad++; $display("FAIL busy_hold got %h want %h", bcd_out, e); end
  endtask

  task automatic test_reset_abort;
    logic [11:0] e;
    bit ok; int dc, a, d0;
    pulse(128, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1 || done !== 1'b0 || bcd_out !== 12'h000) begin
      n_bad++; $display("FAIL abort_state got r=%b d=%b b=%h want r=1 d=0 b=000", ready, done, bcd_out); end
    repeat (15) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL abort_done got %0d want 0", done_cnt - d0); end
    pulse(1, 1'b1);
    wait_done(ok, dc);
    e = exp_q.pop_front(); a = acc_q.pop_front();
    n_cmp++; if (!ok || bcd_out !== e || dc - a !== LAT) begin
      n_bad++; $display("FAIL abort_restart got %h at %0d want %h at %0d", bcd_out, dc - a, e, LAT); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_adj();
    test_single();
    test_sweep();
    test_back_to_back();
    test_busy_start();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
